// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB memory completer family:
//   - apb_state_e     : completer FSM states (IDLE, ACCESS)
//   - apb_err_e       : error-cause codes (ERR_NONE, ERR_MISALIGN, ERR_RANGE)
//   - MAX_WAIT_STATES : largest wait-state count the counter can hold
//   - WAIT_CNT_W      : width of the wait-state counter
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } apb_err_e;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = 4;

endpackage : apb_pkg

// File: rtl/apb_mem_slave_ram.sv
// -----------------------------------------------------------------------------
// apb_mem_slave_ram
// MEM_DEPTH x DATA_WIDTH flop array, byte-enable synchronous write and
// asynchronous (combinational) read.
//
// Ports:
//   i_clk    in   1               write clock (rising edge)
//   i_we     in   1               write enable
//   i_be     in   DATA_WIDTH/8    byte enables, one per byte lane
//   i_addr   in   ADDR_W          word address
//   i_wdata  in   DATA_WIDTH      write data
//   o_rdata  out  DATA_WIDTH      read data for i_addr (0 when beyond depth)
// -----------------------------------------------------------------------------
module apb_mem_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                  w_in_range;

    // A non-power-of-two depth leaves address codes with no backing word.
    assign w_in_range = (32'(i_addr) < 32'(MEM_DEPTH));

    // NOTE: the array has no reset on purpose; contents are undefined until
    // written, which lets the tools map it onto plain enable flops or RAM.
    always_ff @(posedge i_clk) begin
        if (i_we && w_in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = w_in_range ? r_mem[i_addr] : '0;

endmodule : apb_mem_slave_ram

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
// APB3 completer fronting a word-addressed storage array. Inserts WAIT_STATES
// PREADY-low cycles per access and flags misaligned or out-of-range
// addresses with PSLVERR.
//
// Optional feature macro: APB_MEM_SLAVE_PSTRB_EN
//   defined   -> PSTRB port exists; writes update only strobed byte lanes.
//   undefined -> no PSTRB port; every successful write updates the full word.
//
// Ports:
//   PCLK     in   1              clock, rising edge
//   PRESET   in   1              asynchronous active-low reset
//   PSEL     in   1              select
//   PENABLE  in   1              access phase
//   PWRITE   in   1              1 = write, 0 = read
//   PADDR    in   ADDR_WIDTH     byte address
//   PWDATA   in   DATA_WIDTH     write data
//   PSTRB    in   DATA_WIDTH/8   byte write strobes (APB_MEM_SLAVE_PSTRB_EN only)
//   PREADY   out  1              transfer complete
//   PRDATA   out  DATA_WIDTH     read data (0 unless an error-free read completes)
//   PSLVERR  out  1              error response, qualified by PREADY
// -----------------------------------------------------------------------------
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(NBYTES);
    localparam int IDX_W  = ADDR_WIDTH - OFFS_W;
    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("apb_mem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_ws
        $error("apb_mem_slave: WAIT_STATES out of range 0..15");
    end
    if (MEM_DEPTH < 1 || MEM_DEPTH > (2 ** IDX_W)) begin : g_bad_depth
        $error("apb_mem_slave: MEM_DEPTH not addressable by PADDR");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;

    // ---------------------------------------------------------------------
    // Address decode and error classification
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0]      w_index;
    logic                  w_misalign;
    logic                  w_range_err;
    apb_err_e              w_err_cause;
    logic                  w_err;

    assign w_index     = PADDR[ADDR_WIDTH-1:OFFS_W];
    assign w_range_err = (32'(w_index) >= 32'(MEM_DEPTH));

    if (OFFS_W == 0) begin : g_no_offs
        assign w_misalign = 1'b0;
    end else begin : g_offs
        assign w_misalign = |PADDR[OFFS_W-1:0];
    end

    // Misalignment takes priority when both causes are present; either one
    // produces the same PSLVERR, the cause code is kept for visibility.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_err_cause = ERR_NONE;
        if (w_misalign) begin
            w_err_cause = ERR_MISALIGN;
        end else if (w_range_err) begin
            w_err_cause = ERR_RANGE;
        end
    end

    assign w_err = (w_err_cause != ERR_NONE);

    // ---------------------------------------------------------------------
    // FSM: next state and wait counter
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    // Master abandoned the transfer: no write, no response.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Response
    // ---------------------------------------------------------------------
    // Outputs are decoded from registered state, so PRESET forces them to
    // zero at once and the completing edge can never be reached mid-reset.
    logic                    w_pready;
    logic                    w_we;
    logic [NBYTES-1:0]       w_strb;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;

    assign w_pready = (r_state == ACCESS) && (r_cnt == '0) && PSEL && PENABLE;
    assign w_we     = w_pready && PWRITE && !w_err;

`ifdef APB_MEM_SLAVE_PSTRB_EN
    assign w_strb = PSTRB;
`else
    assign w_strb = '1;
`endif

    apb_mem_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_W     (RAM_AW)
    ) u_ram (
        .i_clk   (PCLK),
        .i_we    (w_we),
        .i_be    (w_strb),
        .i_addr  (w_index[RAM_AW-1:0]),
        .i_wdata (PWDATA),
        .o_rdata (w_ram_rdata)
    );

    assign PREADY  = w_pready;
    assign PSLVERR = w_pready && w_err;
    assign PRDATA  = (w_pready && !PWRITE && !w_err) ? w_ram_rdata : '0;

endmodule : apb_mem_slave

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
// Directed self-checking bench for apb_mem_slave at default parameters
// (ADDR_WIDTH=8, DATA_WIDTH=32, MEM_DEPTH=16, WAIT_STATES=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_mem_slave;
    import apb_pkg::*;

    localparam int EXP_ACC = 3;   // WAIT_STATES + 1 access cycles

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PCLK = ~PCLK;

    apb_mem_slave dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
`ifdef APB_MEM_SLAVE_PSTRB_EN
        .PSTRB   (PSTRB),
`endif
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete APB transfer starting just after a rising edge. Returns the
    // response captured in the PREADY cycle and the number of access-phase
    // cycles seen (-1 if PREADY never rose within the budget). Leaves the
    // bus idle just after the completing edge, so a following call issues
    // its setup phase with no idle cycle in between.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic slverr,
                            output int acc);
        int  n;
        bit  done;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0; done = 0; rdata = '0; slverr = 1'b0;
        while (!done && n < 20) begin
            @(negedge PCLK);
            n++;
            if (PREADY) begin
                rdata  = PRDATA;
                slverr = PSLVERR;
                done   = 1;
            end
        end
        acc = done ? n : -1;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          acc;

    initial begin
        PRESET = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PWDATA = '0; PSTRB = 4'hF;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready",  64'(PREADY),  64'h0);
        check("rst_pslverr", 64'(PSLVERR), 64'h0);
        check("rst_prdata",  64'(PRDATA),  64'h0);
        check("rst_state",   64'(dut.r_state), 64'(IDLE));
        PRESET = 1'b1;
        @(posedge PCLK); #1;

        // Write then read the same word.
        apb_xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, acc);
        check("wr04_acc",    64'(acc), 64'(EXP_ACC));
        check("wr04_err",    64'(err), 64'h0);
        apb_xfer(1'b0, 8'h04, 32'h0, 4'hF, rd, err, acc);
        check("rd04_acc",    64'(acc), 64'(EXP_ACC));
        check("rd04_data",   64'(rd),  64'hDEADBEEF);
        check("rd04_err",    64'(err), 64'h0);

        // Out-of-range read (index 16).
        apb_xfer(1'b0, 8'h40, 32'h0, 4'hF, rd, err, acc);
        check("rd40_acc",    64'(acc), 64'(EXP_ACC));
        check("rd40_err",    64'(err), 64'h1);
        check("rd40_data",   64'(rd),  64'h0);

        // Misaligned write must not disturb the aligned word below it.
        apb_xfer(1'b1, 8'h06, 32'h12345678, 4'hF, rd, err, acc);
        check("wr06_err",    64'(err), 64'h1);
        apb_xfer(1'b0, 8'h04, 32'h0, 4'hF, rd, err, acc);
        check("rd04b_data",  64'(rd),  64'hDEADBEEF);
        check("rd04b_err",   64'(err), 64'h0);

        // Back-to-back writes then reads at both ends of the array.
        apb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, err, acc);
        check("b2b_wr0_cyc", 64'(acc + 1), 64'd4);
        apb_xfer(1'b1, 8'h3C, 32'h2, 4'hF, rd, err, acc);
        check("b2b_wr1_cyc", 64'(acc + 1), 64'd4);
        check("b2b_wr1_err", 64'(err), 64'h0);
        apb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, err, acc);
        check("b2b_rd0",     64'(rd),  64'h1);
        apb_xfer(1'b0, 8'h3C, 32'h0, 4'hF, rd, err, acc);
        check("b2b_rd1",     64'(rd),  64'h2);

        // Aborted write (PSEL dropped in access) leaves memory unchanged.
        apb_xfer(1'b1, 8'h10, 32'h0000A5A5, 4'hF, rd, err, acc);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h10; PWDATA = 32'hFFFF0000;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        check("abort_pready", 64'(PREADY), 64'h0);
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, err, acc);
        check("abort_rd10",  64'(rd),  64'h0000A5A5);

        // Reset during the 2nd wait cycle of a write.
        apb_xfer(1'b1, 8'h08, 32'h55AA55AA, 4'hF, rd, err, acc);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h08; PWDATA = 32'hCAFEF00D;
        @(posedge PCLK); #1;          // entered ACCESS, 1st wait cycle
        PENABLE = 1;
        @(posedge PCLK);              // 2nd wait cycle begins
        @(negedge PCLK);
        check("pre_rst_pready", 64'(PREADY), 64'h0);
        PRESET = 1'b0;
        #1;
        check("mid_rst_pready", 64'(PREADY), 64'h0);
        check("mid_rst_state",  64'(dut.r_state), 64'(IDLE));
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("mid_rst_hold",   64'(PREADY), 64'h0);
        PSEL = 0; PENABLE = 0;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, err, acc);
        check("rst_rd08",    64'(rd),  64'h55AA55AA);

`ifdef APB_MEM_SLAVE_PSTRB_EN
        apb_xfer(1'b1, 8'h0C, 32'hAABBCCDD, 4'hF, rd, err, acc);
        apb_xfer(1'b1, 8'h0C, 32'h11223344, 4'b0011, rd, err, acc);
        apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, acc);
        check("strb_rd0c",   64'(rd),  64'hAABB3344);
`else
        // Without strobes every write replaces the full word.
        apb_xfer(1'b1, 8'h0C, 32'hAABBCCDD, 4'hF, rd, err, acc);
        apb_xfer(1'b1, 8'h0C, 32'h11223344, 4'b0011, rd, err, acc);
        apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, acc);
        check("full_rd0c",   64'(rd),  64'h11223344);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_apb_mem_slave

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB3 completer with a word-addressed storage array, programmable wait states and error response (PSLVERR). It succeeds the single-cycle APB slave. It sits behind the APB bridge/master as the standard memory-mapped target and as the DUT for the team's APB UVM environment.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width; byte address.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64.
- MEM_DEPTH, 16, number of DATA_WIDTH words; must be ≤ 2**(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- WAIT_STATES, 2, PREADY-low cycles inserted per access; range 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, asynchronous, active-low.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes. Present only with APB_MEM_SLAVE_PSTRB_EN.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- Word index is PADDR >> log2(DATA_WIDTH/8).
- The address is misaligned when PADDR low log2(DATA_WIDTH/8) bits ≠ 0.
- The address is out of range when index ≥ MEM_DEPTH.
- Either condition is an error.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS on an edge with PSEL=1, PENABLE=0 (setup phase). The wait counter loads WAIT_STATES at that edge.
  - In ACCESS, an edge with cnt≠0 decrements cnt.
  - In ACCESS, an edge with cnt=0 completes the transfer and returns to IDLE.
  - In ACCESS, an edge with PSEL=0 or PENABLE=0 aborts: return to IDLE, no write, no response.
- PREADY = (state==ACCESS) && cnt==0 && PSEL && PENABLE.
- Write commits at the completing edge, only if no error. An errored write leaves memory unchanged.
- PRDATA = mem[index] while PREADY=1 and the read has no error; otherwise 0.
- PSLVERR = PREADY && error.
- Back-to-back transfers: a new setup phase in the cycle immediately after completion is accepted normally from IDLE.
- PADDR, PWRITE, PWDATA and PSTRB are sampled only during access. The master holds them stable; the slave does not latch them in setup.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, cnt=0. Memory contents are not reset (undefined until written).
- PRESET assertion mid-access forces the outputs to their reset values immediately (asynchronous) and drops any pending write.
- Access latency is WAIT_STATES+1 access-phase cycles. The full transfer is WAIT_STATES+2 cycles including setup.
- WAIT_STATES=0: PREADY=1 in the first access cycle (zero-wait APB).
- Read-after-write to the same address in consecutive transfers returns the new data.

## Configuration
- APB_MEM_SLAVE_PSTRB_EN defined: the PSTRB port exists. A write updates only bytes whose strobe is 1. PSTRB is ignored on reads.
- APB_MEM_SLAVE_PSTRB_EN undefined: no PSTRB port. Every successful write updates the full word.

## Structure
- Shared package apb_pkg holds:
  - the FSM state enum (IDLE, ACCESS);
  - the error-cause constants (ERR_NONE, ERR_MISALIGN, ERR_RANGE);
  - the max WAIT_STATES constant (15).
- Sub-module apb_mem_slave_ram: MEM_DEPTH×DATA_WIDTH flop array with byte-enable synchronous write and asynchronous read.
- The top level holds the FSM, wait counter, address decode and error logic.

## Test plan
All scenarios use the defaults (ADDR_WIDTH=8, DATA_WIDTH=32, MEM_DEPTH=16, WAIT_STATES=2).
- Write 0xDEADBEEF @0x04, then read @0x04 → PREADY high in the 3rd access cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
- Read @0x40 (index 16) → PREADY after 2 waits; PSLVERR=1; PRDATA=0.
- Write 0x12345678 @0x06 (misaligned) → PSLVERR=1. A later read @0x04 still returns 0xDEADBEEF.
- Back-to-back writes @0x00=0x1 and @0x3C=0x2 with no idle cycle, then reads → 0x1 and 0x2. Each transfer takes 4 cycles.
- PRESET low during the 2nd wait cycle of a write 0xCAFEF00D @0x08 → PREADY=0 immediately, FSM in IDLE. The @0x08 contents are unchanged.
- With APB_MEM_SLAVE_PSTRB_EN: write 0xAABBCCDD @0x0C, then write 0x11223344 with PSTRB=4'b0011 → a read @0x0C returns 0xAABB3344.
